quiz_arbiter: RTL and testbench
===============================

# quiz_arbiter

Round controller for the quiz buzzer path. Takes the single-cycle press triggers of four debounced `button` instances and runs a round: the host arms it, the first valid press wins, and simultaneous presses are resolved by rotating priority. It drives each button's `lock` input, holds the winner for an answer window, and reports timeouts. It sits between the `button` instances and the `buzzer`/display logic.

## Interface

Parameters:
- `ARM_CMAX`, default 32'd50_000_000: clock cycles the armed round waits for a press before timing out (≥1).
- `ANS_CMAX`, default 32'd250_000_000: clock cycles the winner is held before the round ends (≥1).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tr_p`  in  4  per-player press trigger, one-cycle pulse from `button`.
- `tr_arm`  in  1  host pulse: start a round.
- `tr_clr`  in  1  host pulse: abort or finish the round and return to IDLE.
- `lock`  out  4  per-player lock to `button`. 1 means that player's presses are ignored.
- `win_vld`  out  1  a winner is held.
- `win_id`  out  2  index of the winner. Valid while `win_vld`=1.
- `timeout`  out  1  the armed window expired with no press.
- `early`  out  4  per-player false-start flags.
- `busy`  out  1  state ≠ IDLE.

## Operation

- The FSM has four states: IDLE, ARMED, GRANT, DONE. Encoding is free.
- IDLE: `lock`=4'b0000. On `tr_arm` → ARMED and load the window counter with 0.
- ARMED: counts up each cycle.
  - Eligible presses are `tr_p & ~early`.
  - If any eligible press occurs → GRANT. The winner is the first set bit scanning from `prio` upward, modulo 4.
  - Else if the counter reaches ARM_CMAX−1 → DONE with `timeout`=1.
  - If every player is flagged early, the round still times out normally.
- GRANT: `win_vld`=1, `win_id` is held, and `lock`=4'b1111.
  - The counter runs from 0. At ANS_CMAX−1 → DONE.
  - `prio` ← `win_id`+1 (2-bit wrap).
- DONE: `lock`=4'b1111. `win_vld`/`win_id` or `timeout` hold until `tr_clr`.
- `tr_arm` is ignored in every state except IDLE.
- `tr_clr` in any state → IDLE at the next edge.
  - Clears `win_vld`, `timeout`, `early`, and the counter.
  - `prio` is kept.
  - `tr_clr` has priority over every other event in the same cycle, including a press or `tr_arm`.
- Presses in GRANT or DONE are ignored.
- Counter width is 32 bits and it never wraps. Terminal compares use `==`.

## Timing

- Reset values:
  - state=IDLE, `prio`=2'd0, counter=0.
  - `lock`=4'b0000, `win_vld`=0, `win_id`=2'd0, `timeout`=0, `early`=4'b0000, `busy`=0.
- All outputs are registered.
- Press latency: `tr_p` high at edge N → `win_vld`, `win_id` and `lock`=4'b1111 valid after edge N+1.
- Presses in the same cycle as the arming `tr_arm` are not counted, because the state is still IDLE at that edge.
- Lock behaviour by state:
  - ARMED: `lock` equals `early`, so flagged players stay locked.
  - GRANT and DONE: all players are locked.
- Timeout: the ARMED→DONE transition happens ARM_CMAX cycles after entering ARMED. `timeout` goes high on the same edge.
- GRANT lasts exactly ANS_CMAX cycles.
- Reset mid-round: asynchronous return to the reset values, with no glitch on `lock` beyond the clear itself.

## Configuration

- `QUIZ_FALSE_START_EN` defined:
  - A `tr_p` bit seen in IDLE sets the matching `early` bit.
  - That player stays locked and ineligible for the following round.
  - `early` clears only on `tr_clr` or reset. Since `tr_clr` returns to IDLE, it clears flags from the previous round; flags raised after the clear persist.
- Not defined:
  - Presses in IDLE are ignored.
  - `early` is tied to 4'b0000, and eligible presses are simply `tr_p`.

## Test plan

- Basic round: reset, `tr_arm`, then `tr_p`=4'b0100 after 10 cycles → `win_vld`=1, `win_id`=2, `lock`=4'b1111 one edge later. DONE after ANS_CMAX cycles, then `tr_clr` → IDLE with `lock`=0.
- Tie and rotation (ANS_CMAX=5):
  - Round 1: `tr_p`=4'b1111 → `win_id`=0.
  - Round 2: `tr_p`=4'b1111 → `win_id`=1.
  - Round 3: `tr_p`=4'b1001 → `win_id`=3.
- Timeout with ARM_CMAX=20: arm and send no press → `timeout`=1 exactly 20 cycles after the arming edge, `win_vld`=0, and it holds until `tr_clr`.
- Simultaneous events:
  - `tr_clr` and `tr_p`=4'b0001 in the same ARMED cycle → IDLE, no winner.
  - `tr_arm` with `tr_p`=4'b0010 in the same cycle → ARMED, no winner.
- False start (macro defined):
  - `tr_p`=4'b0010 in IDLE → `early`=4'b0010.
  - Arm → `lock`=4'b0010.
  - `tr_p`=4'b0011 → `win_id`=0.
  - With the macro undefined, the same stimulus gives `early`=0 and `win_id` per rotating priority.
- Reset mid-GRANT: drop `rst_n` asynchronously → all outputs at reset values before the next edge, and `prio` returns to 0.

Source files
------------

// File: rtl/quiz_arbiter.sv
// rtl/quiz_arbiter.sv - quiz round controller: arm, first-press grant with rotating tie priority, answer hold, timeout
// Optional false-start flagging is enabled by defining QUIZ_FALSE_START_EN.
module quiz_arbiter #(
  parameter logic [31:0] ARM_CMAX = 32'd50_000_000,
  parameter logic [31:0] ANS_CMAX = 32'd250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tr_p,
  input  logic       tr_arm,
  input  logic       tr_clr,
  output logic [3:0] lock,
  output logic       win_vld,
  output logic [1:0] win_id,
  output logic       timeout,
  output logic [3:0] early,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GRANT, S_DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  prio, prio_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  elig;
  logic [3:0]  early_nx;
  logic [3:0]  lock_d;
  logic        win_vld_d, timeout_d, busy_d;
  logic [1:0]  win_id_d;
  logic [1:0]  pick;

  // First requesting index scanning upward from start, wrapping modulo 4.
  function automatic logic [1:0] first_from(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    first_from = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) first_from = idx;
    end
  endfunction

  assign pick = first_from(elig, prio);

`ifdef QUIZ_FALSE_START_EN
  logic [3:0] early_q;

  assign elig  = tr_p & ~early_q;
  assign early = early_q;

  always_comb begin
    early_nx = early_q;
    if (tr_clr)
      early_nx = 4'b0000;
    else if (state == S_IDLE)
      early_nx = early_q | tr_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) early_q <= 4'b0000;
    else        early_q <= early_nx;
  end
`else
  assign elig     = tr_p;
  assign early    = 4'b0000;
  assign early_nx = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (tr_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (tr_arm) state_d = S_ARMED;
        S_ARMED: begin
          if (|elig)                          state_d = S_GRANT;
          else if (cnt == ARM_CMAX - 32'd1)   state_d = S_DONE;
        end
        S_GRANT: if (cnt == ANS_CMAX - 32'd1) state_d = S_DONE;
        default: state_d = state;
      endcase
    end
  end

  // Next values for the registered outputs, derived from the current and next state.
  always_comb begin
    cnt_d     = cnt;
    prio_d    = prio;
    win_vld_d = win_vld;
    win_id_d  = win_id;
    timeout_d = timeout;
    if (tr_clr) begin
      cnt_d     = 32'd0;
      win_vld_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: cnt_d = 32'd0;
        S_ARMED: begin
          if (|elig) begin
            win_vld_d = 1'b1;
            win_id_d  = pick;
            prio_d    = pick + 2'd1;
            cnt_d     = 32'd0;
          end else if (state_d == S_DONE) begin
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt + 32'd1;
          end
        end
        S_GRANT: if (state_d == S_GRANT) cnt_d = cnt + 32'd1;
        default: cnt_d = cnt;
      endcase
    end

    case (state_d)
      S_IDLE:  lock_d = 4'b0000;
      S_ARMED: lock_d = early_nx;
      default: lock_d = 4'b1111;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 32'd0;
      prio    <= 2'd0;
      win_vld <= 1'b0;
      win_id  <= 2'd0;
      timeout <= 1'b0;
      lock    <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      prio    <= prio_d;
      win_vld <= win_vld_d;
      win_id  <= win_id_d;
      timeout <= timeout_d;
      lock    <= lock_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb/tb_quiz_arbiter.sv - randomized + directed scoreboard bench for quiz_arbiter
// Expected outputs come from a countdown-based round model; a monitor compares them after each edge.
module tb_quiz_arbiter;

  localparam int ARM = 20;
  localparam int ANS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tr_p;
  logic       tr_arm, tr_clr;
  logic [3:0] lock, early;
  logic       win_vld, timeout, busy;
  logic [1:0] win_id;

  quiz_arbiter #(.ARM_CMAX(32'(ARM)), .ANS_CMAX(32'(ANS))) dut (
    .clk(clk), .rst_n(rst_n), .tr_p(tr_p), .tr_arm(tr_arm), .tr_clr(tr_clr),
    .lock(lock), .win_vld(win_vld), .win_id(win_id), .timeout(timeout),
    .early(early), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lock;
    logic       win_vld;
    logic [1:0] win_id;
    logic       timeout;
    logic [3:0] early;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Round model: phase 0 waiting, 1 armed, 2 winner held, 3 finished; m_left counts cycles remaining.
  int         m_phase, m_left, m_prio, m_win_id;
  logic       m_win_vld, m_timeout;
  logic [3:0] m_early;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_prio = 0; m_win_id = 0;
    m_win_vld = 1'b0; m_timeout = 1'b0; m_early = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] p, input logic arm, input logic clr);
    logic [3:0] elig;
    bit found;
    if (clr) begin
      m_phase = 0; m_win_vld = 1'b0; m_timeout = 1'b0; m_early = 4'b0000;
      return;
    end
    case (m_phase)
      0: begin
`ifdef QUIZ_FALSE_START_EN
        m_early = m_early | p;
`endif
        if (arm) begin m_phase = 1; m_left = ARM; end
      end
      1: begin
        elig = p & ~m_early;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (m_prio + k) % 4;
          if (!found && elig[j]) begin
            found = 1; m_win_id = j;
          end
        end
        if (found) begin
          m_win_vld = 1'b1; m_prio = (m_win_id + 1) % 4;
          m_phase = 2; m_left = ANS;
        end else begin
          m_left--;
          if (m_left == 0) begin m_phase = 3; m_timeout = 1'b1; end
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lock    = (m_phase == 0) ? 4'b0000 : (m_phase == 1) ? m_early : 4'b1111;
    e.win_vld = m_win_vld;
    e.win_id  = 2'(m_win_id);
    e.timeout = m_timeout;
    e.early   = m_early;
    e.busy    = (m_phase != 0);
    return e;
  endfunction

  task automatic drive(input logic [3:0] p, input logic arm, input logic clr);
    @(posedge clk);
    #2;
    tr_p = p; tr_arm = arm; tr_clr = clr;
    model_step(p, arm, clr);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    n_vec++;
    if (lock !== 4'b0000 || win_vld !== 1'b0 || win_id !== 2'd0 || timeout !== 1'b0 ||
        early !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got lock=%b vld=%b id=%0d to=%b early=%b busy=%b, want all zero",
               tag, lock, win_vld, win_id, timeout, early, busy);
    end
  endtask

  // Monitor: outputs are registered, so each edge presents one expected record.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (lock !== e.lock || win_vld !== e.win_vld || timeout !== e.timeout ||
          early !== e.early || busy !== e.busy || (e.win_vld && win_id !== e.win_id)) begin
        n_bad++;
        $display("FAIL outputs cyc %0d: got lock=%b vld=%b id=%0d to=%b early=%b busy=%b, want lock=%b vld=%b id=%0d to=%b early=%b busy=%b",
                 cyc, lock, win_vld, win_id, timeout, early, busy,
                 e.lock, e.win_vld, e.win_id, e.timeout, e.early, e.busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0; tr_p = 4'b0000; tr_arm = 1'b0; tr_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check_reset("reset_state");
    @(posedge clk); #2; rst_n = 1'b1;

    // Tie resolution and rotation.
    drive(4'b0000, 1'b1, 1'b0); idle(2); drive(4'b1111, 1'b0, 1'b0); idle(ANS + 2); drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0); idle(2); drive(4'b1111, 1'b0, 1'b0); idle(ANS + 2); drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0); idle(2); drive(4'b1001, 1'b0, 1'b0); idle(ANS + 2); drive(4'b0000, 1'b0, 1'b1);

    // Basic round.
    idle(2); drive(4'b0000, 1'b1, 1'b0); idle(10); drive(4'b0100, 1'b0, 1'b0);
    idle(ANS + 3); drive(4'b0000, 1'b0, 1'b1); idle(2);

    // Timeout holds until clear.
    drive(4'b0000, 1'b1, 1'b0); idle(ARM + 5); drive(4'b0000, 1'b0, 1'b1); idle(1);

    // Simultaneous events.
    drive(4'b0000, 1'b1, 1'b0); idle(2); drive(4'b0001, 1'b0, 1'b1); idle(2);
    drive(4'b0010, 1'b1, 1'b0); idle(3); drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1); drive(4'b0010, 1'b0, 1'b0); drive(4'b0000, 1'b1, 1'b0);
    idle(2); drive(4'b0011, 1'b0, 1'b0); idle(ANS + 2); drive(4'b0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a grant.
    drive(4'b0000, 1'b1, 1'b0); idle(1); drive(4'b0100, 1'b0, 1'b0); idle(2);
    @(posedge clk); #3;
    rst_n = 1'b0; tr_p = 4'b0000; tr_arm = 1'b0; tr_clr = 1'b0;
    #1;
    check_reset("reset_mid_grant");
    model_reset();
    @(posedge clk); #2; rst_n = 1'b1;
    drive(4'b0000, 1'b1, 1'b0); idle(1); drive(4'b1111, 1'b0, 1'b0); idle(ANS + 1); drive(4'b0000, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      drive(p, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
    end
    drive(4'b0000, 1'b0, 1'b0);

    @(posedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
